// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use stall control
// with a saturating stall-cycle statistics counter.
module fwd_hazard_unit #(
  parameter int REG_AW      = 3,
  parameter int NUM_FWD     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REG_AW-1:0]           ex_rs,
  input  logic [REG_AW-1:0]           ex_rt,
  input  logic                        ex_uses_imm,
  input  logic [NUM_FWD*REG_AW-1:0]   stg_rd,
  input  logic [NUM_FWD-1:0]          stg_we,
  input  logic                        id_valid,
  input  logic [REG_AW-1:0]           id_rs,
  input  logic [REG_AW-1:0]           id_rt,
  input  logic                        id_uses_rt,
  input  logic                        ex_is_load,
  input  logic                        ex_we,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        flush,
  input  logic                        stat_clr,
  output logic [$clog2(NUM_FWD+2)-1:0] alu_src1,
  output logic [$clog2(NUM_FWD+2)-1:0] alu_src2,
  output logic [$clog2(NUM_FWD+2)-1:0] mem_wr_sel,
  output logic                        stall,
  output logic [15:0]                 stall_cnt
);

  localparam int SEL_W = $clog2(NUM_FWD+2);
  localparam int CW    = $clog2(LOAD_LAT+1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic            rs_zero, rt_zero, rd_zero;
  logic            hazard;

  assign rs_zero = (ZERO_REG_EN != 0) && (ex_rs == '0);
  assign rt_zero = (ZERO_REG_EN != 0) && (ex_rt == '0);
  assign rd_zero = (ZERO_REG_EN != 0) && (ex_rd == '0);

  // Scan oldest to newest so the nearest matching stage wins.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (stg_we[k] && stg_rd[k*REG_AW +: REG_AW] == ex_rs && !rs_zero)
        rs_sel = SEL_W'(k+1);
      if (stg_we[k] && stg_rd[k*REG_AW +: REG_AW] == ex_rt && !rt_zero)
        rt_sel = SEL_W'(k+1);
    end
  end

  assign alu_src1   = rs_sel;
  assign alu_src2   = ex_uses_imm ? SEL_W'(NUM_FWD+1) : rt_sel;
  assign mem_wr_sel = rt_sel;

  assign hazard = id_valid && ex_is_load && ex_we && !flush && !rd_zero &&
                  ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hazard) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CW'(LOAD_LAT-1);
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      stall   = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
